// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/exec sequencer driving ProgramCounter PS/PC_IN.
// Optional taken-transfer counter enabled by defining PCSEQ_BRCNT_EN.
module pc_sequencer
`ifdef PCSEQ_BRCNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic [3:0]  status,
    output logic        fetch_req,
    output logic [1:0]  PS,
    output logic [31:0] PC_IN,
    output logic        halted
`ifdef PCSEQ_BRCNT_EN
    ,
    output logic [CNT_W-1:0] taken_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_LOAD = 2'b10;
    localparam logic [1:0] PS_ADD  = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [1:0]  ps_q, ps_d;
    logic [31:0] pc_in_q, pc_in_d;
    logic        fetch_req_q, fetch_req_d;
    logic        halted_q, halted_d;

    logic        flag_n, flag_z, flag_c, flag_v;
    logic        cond_ok;
    logic        is_br, is_jmp, is_halt;
    logic [1:0]  dec_ps;
    logic [31:0] dec_pc_in;

    assign flag_n = status[3];
    assign flag_z = status[2];
    assign flag_c = status[1];
    assign flag_v = status[0];

    assign is_br   = (instr_q[31:28] == 4'hE);
    assign is_jmp  = (instr_q[31:28] == 4'hF) && !instr_q[27];
    assign is_halt = (instr_q[31:28] == 4'hF) && instr_q[27];

    // Branch condition against the live flags; only consumed in DECODE.
    always_comb begin
        cond_ok = 1'b0;
        case (instr_q[27:24])
            4'd0:    cond_ok = 1'b1;
            4'd1:    cond_ok = flag_z;
            4'd2:    cond_ok = !flag_z;
            4'd3:    cond_ok = flag_c;
            4'd4:    cond_ok = !flag_c;
            4'd5:    cond_ok = flag_n;
            4'd6:    cond_ok = !flag_n;
            4'd7:    cond_ok = flag_v;
            4'd8:    cond_ok = !flag_v;
            4'd9:    cond_ok = (flag_n == flag_v);
            4'd10:   cond_ok = (flag_n != flag_v);
            4'd11:   cond_ok = !flag_z && (flag_n == flag_v);
            4'd12:   cond_ok = flag_z || (flag_n != flag_v);
            default: cond_ok = 1'b0;
        endcase
    end

    // Classify the latched word into the PS command it will issue.
    always_comb begin
        dec_ps    = PS_INC;
        dec_pc_in = '0;
        unique case (1'b1)
            is_br: begin
                if (cond_ok) begin
                    dec_ps    = PS_ADD;
                    dec_pc_in = {{8{instr_q[23]}}, instr_q[23:0]};
                end
            end
            is_jmp: begin
                dec_ps    = PS_LOAD;
                dec_pc_in = {5'b0, instr_q[26:0]};
            end
            is_halt: begin
                dec_ps    = PS_HOLD;
                dec_pc_in = '0;
            end
            default: begin
                dec_ps    = PS_INC;
                dec_pc_in = '0;
            end
        endcase
    end

    // Next state and next registered outputs; PS is non-zero only in EXEC.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        ps_d    = PS_HOLD;
        pc_in_d = '0;
        case (state_q)
            S_FETCH: begin
                if (enable && instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                    ps_d    = dec_ps;
                    pc_in_d = dec_pc_in;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        fetch_req_d = (state_d == S_FETCH) && enable;
        halted_d    = (state_d == S_HALT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            instr_q     <= '0;
            ps_q        <= PS_HOLD;
            pc_in_q     <= '0;
            fetch_req_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            ps_q        <= ps_d;
            pc_in_q     <= pc_in_d;
            fetch_req_q <= fetch_req_d;
            halted_q    <= halted_d;
        end
    end

    assign fetch_req = fetch_req_q;
    assign PS        = ps_q;
    assign PC_IN     = pc_in_q;
    assign halted    = halted_q;

`ifdef PCSEQ_BRCNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count EXEC cycles that load or add to the PC, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_EXEC) && ps_q[1] && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register; reset drops any in-flight increment.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign taken_count = cnt_q;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control sequencer that drives the program counter's `PS` select and `PC_IN` operand. Per instruction it fetches an instruction word from instruction memory through a valid/request handshake, decodes control-flow opcodes, evaluates branch conditions against the datapath `status` flags, and issues exactly one PC update command. It sits between instruction memory, the status register and the `ProgramCounter` block.

## Interface
Parameters:
- `CNT_W`, 16, width of the taken-branch counter (present only with `PCSEQ_BRCNT_EN`).

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  run enable; sampled only in FETCH.
- `instr`  in  32  instruction word from memory; valid when `instr_valid`=1.
- `instr_valid`  in  1  memory response strobe.
- `status`  in  4  flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- `fetch_req`  out  1  instruction request to memory.
- `PS`  out  2  PC select: 00 hold, 01 PC+1, 10 load `PC_IN`, 11 PC+`PC_IN`.
- `PC_IN`  out  32  PC operand.
- `halted`  out  1  HALT executed.
- `taken_count`  out  `CNT_W`  taken control transfers (only with `PCSEQ_BRCNT_EN`).

## Operation
- States: FETCH, DECODE, EXEC, HALT.
- FETCH: `fetch_req`=`enable`. If `enable`=1 and `instr_valid`=1, latch `instr` and go to DECODE; otherwise stay. `instr_valid` is ignored in all other states.
- DECODE: classify the latched word and sample `status`, then go to EXEC (or to HALT for a HALT opcode). Flags are sampled only in this cycle.
- EXEC: drive the decided `PS`/`PC_IN` for exactly one cycle, then go to FETCH.
- HALT: `halted`=1. Stays in HALT until reset.
- Decode of `instr[31:28]`:
  - 4'b1110: conditional relative branch. `cond`=`instr[27:24]`; `PC_IN` is the sign-extended `instr[23:0]`. Taken gives PS=11; not taken gives PS=01 with `PC_IN`=0.
  - 4'b1111 with `instr[27]`=0: absolute jump. PS=10; `PC_IN` is the zero-extended `instr[26:0]`.
  - 4'b1111 with `instr[27]`=1: HALT. No EXEC cycle; PS remains 00.
  - Any other value: sequential. PS=01, `PC_IN`=0.
- Condition codes:
  - 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 V, 8 !V.
  - 9 N==V, 10 N!=V, 11 !Z&(N==V), 12 Z|(N!=V).
  - 13–15 never.
- An offset of 0 with the branch taken is legal: PS=11, `PC_IN`=0.
- Sign-extension uses `instr[23]`. Offset wrap-around is handled by the PC adder (mod 2^32) and needs no special handling here.

## Timing
- Outputs are registered. In every state except EXEC: PS=00, `PC_IN`=0.
- Reset (`reset`=0 at an edge):
  - state=FETCH, PS=00, `PC_IN`=0, `fetch_req`=0, `halted`=0, latched instruction cleared, `taken_count`=0.
  - Applies from any state, including mid-EXEC and HALT. A PS command in flight is dropped.
- `fetch_req` is registered. It reads 1 in the first cycle after reset is released when `enable`=1.
- Minimum latency is 3 cycles per instruction: `instr_valid` accepted at edge n, DECODE in cycle n..n+1, EXEC in cycle n+1..n+2 with PS asserted, and PC updated at edge n+2.
- `enable` falling during DECODE/EXEC does not abort the instruction. It takes effect at the next FETCH.
- The HALT instruction asserts `halted` one cycle after DECODE.

## Configuration
- `PCSEQ_BRCNT_EN` defined:
  - `taken_count` exists.
  - It increments by 1 in each EXEC cycle with PS=10 or PS=11, and saturates at all-ones.
- Not defined: no `taken_count` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset then sequential op: `reset`=0 for 2 cycles, `enable`=1, `instr`=32'h0000_0001 valid one cycle → PS=01 for exactly one cycle, 2 cycles after acceptance; PS=00 otherwise; PC advances 0→1.
- Conditional branches: with `status`=4'b0100 (Z=1), `instr`=32'hE100_0005 (EQ, +5) → PS=11, `PC_IN`=5; with `status`=0 the same word → PS=01, `PC_IN`=0.
- Negative offset and jump: `instr`=32'hE0FF_FFFE → PS=11, `PC_IN`=32'hFFFF_FFFE; `instr`=32'hF000_0040 → PS=10, `PC_IN`=32'h40.
- Signed conditions: `cond`=11 (GT) with N=1,V=1,Z=0 → taken; with N=1,V=0 → not taken; `cond`=14 → never taken.
- Stall and HALT: hold `instr_valid`=0 for 10 cycles → remains in FETCH with PS=00 and `fetch_req`=1; then `instr`=32'hF800_0000 → `halted`=1 and PS=00 forever; `reset`=0 for one cycle → `halted`=0 and back in FETCH.
- Reset mid-EXEC: assert `reset` during the PS=11 cycle → PS=00 next cycle; with `PCSEQ_BRCNT_EN`, `taken_count` is 0 afterwards and counts to 3 after three taken branches.
